// File: rtl/scatter_a.sv
// A-operand feeder for the systolic array: streams R row-words from the A-side
// BRAM and skews them diagonally so that lane i lags lane 0 by i cycles.
module scatter_a #(
  parameter int W             = 8,
  parameter int N             = 16,
  parameter int BRAM_W        = 256,
  parameter int BRAM_AW       = 10,
  parameter int DATA_A_SIZE_Y = 64,
  parameter int BASE_ADDR     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_cal,
  output logic                      scatter_done,
  output logic                      busy,
  output logic                      bram_clk_a,
  output logic                      bram_en_a,
  output logic                      bram_we_a,
  output logic [BRAM_AW-1:0]        bram_addr_a,
  output logic [BRAM_W-1:0]         bram_wrdata_a,
  input  logic [BRAM_W-1:0]         bram_rddata_a,
  output logic [N-1:0][W-1:0]       a_ins,
  output logic [N-1:0]              a_valid
);

  localparam int R  = DATA_A_SIZE_Y;
  localparam int CW = $clog2((R > N + 1) ? R : (N + 1)) + 1;
  localparam logic [BRAM_AW-1:0] BASE       = BRAM_AW'(BASE_ADDR);
  localparam logic [CW-1:0]      LAST_ROW   = CW'(R - 1);
  localparam logic [CW-1:0]      DRAIN_LAST = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_rd_vld;

  assign bram_clk_a    = clk;
  assign bram_we_a     = 1'b0;
  assign bram_wrdata_a = {BRAM_W{1'b0}};

  // Pass sequencer: row counter in READ, drain counter sized so the last lane empties before DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= {CW{1'b0}};
      bram_en_a    <= 1'b0;
      bram_addr_a  <= BASE;
      busy         <= 1'b0;
      scatter_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          scatter_done <= 1'b0;
          if (start_cal) begin
            r_state     <= S_READ;
            r_cnt       <= {CW{1'b0}};
            bram_en_a   <= 1'b1;
            bram_addr_a <= BASE;
            busy        <= 1'b1;
          end else begin
            bram_en_a   <= 1'b0;
            busy        <= 1'b0;
          end
        end
        S_READ: begin
          if (r_cnt == LAST_ROW) begin
            r_state   <= S_DRAIN;
            r_cnt     <= {CW{1'b0}};
            bram_en_a <= 1'b0;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            bram_addr_a <= bram_addr_a + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == DRAIN_LAST) begin
            r_state      <= S_DONE;
            scatter_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          scatter_done <= 1'b0;
          busy         <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          bram_en_a    <= 1'b0;
          busy         <= 1'b0;
          scatter_done <= 1'b0;
        end
      endcase
    end
  end

  // Valid skew: read data is valid one cycle after enable, then lane i sees it i cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_vld <= 1'b0;
      a_valid  <= {N{1'b0}};
    end else begin
      r_rd_vld <= bram_en_a;
      a_valid  <= {a_valid[N-2:0], r_rd_vld};
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [W-1:0] r_pipe [0:gi];

    // Lane delay line; zero is loaded when no row is valid so idle lanes never show stale data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= gi; j++) begin
          r_pipe[j] <= {W{1'b0}};
        end
      end else begin
        r_pipe[0] <= r_rd_vld ? bram_rddata_a[gi*W +: W] : {W{1'b0}};
        for (int j = 1; j <= gi; j++) begin
          r_pipe[j] <= r_pipe[j-1];
        end
      end
    end

    assign a_ins[gi] = r_pipe[gi];
  end

  if (BRAM_W > N * W) begin : g_unused
    logic w_unused_hi;
    assign w_unused_hi = ^bram_rddata_a[BRAM_W-1:N*W];
  end

endmodule

// File: tb/tb_scatter_a.sv
// Bench for scatter_a: per-cycle output prediction from pass start time plus
// table-driven passes, back-to-back, mid-pass reset and randomized passes.
module tb_scatter_a;
  localparam int W        = 8;
  localparam int N        = 16;
  localparam int BW       = 256;
  localparam int AW       = 10;
  localparam int R        = 64;
  localparam int BASE     = 100;
  localparam int DONE_OFF = R + N + 2;
  localparam int PASS_LEN = R + N + 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start_cal = 1'b0;
  logic                 scatter_done, busy, bram_clk_a, bram_en_a, bram_we_a;
  logic [AW-1:0]        bram_addr_a;
  logic [BW-1:0]        bram_wrdata_a;
  logic [BW-1:0]        bram_rddata_a;
  logic [N-1:0][W-1:0]  a_ins;
  logic [N-1:0]         a_valid;

  logic [BW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit have_pass = 1'b0;
  int done_q[$];

  typedef struct {
    int pat;
    int i1;
    int i2;
    int exp_n;
    int exp_off;
  } vec_t;

  scatter_a #(.W(W), .N(N), .BRAM_W(BW), .BRAM_AW(AW), .DATA_A_SIZE_Y(R), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .start_cal(start_cal), .scatter_done(scatter_done), .busy(busy),
    .bram_clk_a(bram_clk_a), .bram_en_a(bram_en_a), .bram_we_a(bram_we_a),
    .bram_addr_a(bram_addr_a), .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a),
    .a_ins(a_ins), .a_valid(a_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en_a) bram_rddata_a <= mem[bram_addr_a];
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pass tracker: a start is accepted only when no pass covers the ending cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      have_pass <= 1'b0;
    end else if (start_cal && (!have_pass || (cyc > t0 + DONE_OFF))) begin
      have_pass <= 1'b1;
      t0        <= cyc;
    end
  end

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] elem(input int k, input int i);
    logic [BW-1:0] w;
    w = mem[BASE + k];
    return w[i*W +: W];
  endfunction

  // Per-cycle expectation derived from the pass start cycle
  always @(negedge clk) begin
    logic [N-1:0][W-1:0] e_ins;
    logic [N-1:0]        e_vld;
    logic                e_en, e_done, e_busy;
    int                  d, k;
    e_ins = '0; e_vld = '0; e_en = 1'b0; e_done = 1'b0; e_busy = 1'b0;
    if (!rst && have_pass) begin
      d      = cyc - t0;
      e_en   = (d >= 1) && (d <= R);
      e_done = (d == DONE_OFF);
      e_busy = (d >= 1) && (d <= DONE_OFF);
      for (int i = 0; i < N; i++) begin
        k = d - 3 - i;
        if (k >= 0 && k < R) begin
          e_vld[i] = 1'b1;
          e_ins[i] = elem(k, i);
        end
      end
      if (e_en) chk("addr", BW'(bram_addr_a), BW'(BASE + d - 1));
    end
    if (rst) chk("rst_addr", BW'(bram_addr_a), BW'(BASE));
    chk("en", BW'(bram_en_a), BW'(e_en));
    chk("ains", BW'(a_ins), BW'(e_ins));
    chk("avalid", BW'(a_valid), BW'(e_vld));
    chk("done", BW'(scatter_done), BW'(e_done));
    chk("busy", BW'(busy), BW'(e_busy));
    chk("we", BW'(bram_we_a), BW'(0));
    chk("wrdata", bram_wrdata_a, BW'(0));
    if (scatter_done) done_q.push_back(cyc);
  end

  task automatic fill(input int pat);
    logic [BW-1:0] w;
    logic [W-1:0]  b;
    for (int r = 0; r < R; r++) begin
      for (int j = 0; j < BW/32; j++) w[j*32 +: 32] = $urandom;
      for (int i = 0; i < N; i++) begin
        case (pat)
          0:       b = W'((r*16 + i) & 255);
          1:       b = W'($urandom);
          2:       b = 8'hFF;
          3:       b = W'(((r*3) ^ (i*37)) & 255);
          default: b = 8'h00;
        endcase
        w[i*W +: W] = b;
      end
      mem[BASE + r] = w;
    end
  endtask

  task automatic run_pass(input int pat, input int i1, input int i2, input int exp_n, input int exp_off);
    int ts;
    fill(pat);
    done_q.delete();
    @(negedge clk);
    start_cal = 1'b1;
    ts = cyc;
    for (int n = 1; n <= PASS_LEN + 4; n++) begin
      @(negedge clk);
      start_cal = (cyc == ts + i1) || (cyc == ts + i2);
    end
    start_cal = 1'b0;
    chk("ndone", BW'(done_q.size()), BW'(exp_n));
    if (done_q.size() > 0) chk("tdone", BW'(done_q[0] - ts), BW'(exp_off));
  endtask

  initial begin
    vec_t tbl[5];
    int   ts;
    tbl[0] = '{0, -1, -1, 1, DONE_OFF};
    tbl[1] = '{0, 10, 40, 1, DONE_OFF};
    tbl[2] = '{1, 1, 82, 1, DONE_OFF};
    tbl[3] = '{2, -1, -1, 1, DONE_OFF};
    tbl[4] = '{3, 5, 60, 1, DONE_OFF};

    // asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("r_en", BW'(bram_en_a), BW'(0));
    chk("r_busy", BW'(busy), BW'(0));
    chk("r_done", BW'(scatter_done), BW'(0));
    chk("r_valid", BW'(a_valid), BW'(0));
    chk("r_ains", BW'(a_ins), BW'(0));
    chk("r_addr", BW'(bram_addr_a), BW'(BASE));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_pass(tbl[v].pat, tbl[v].i1, tbl[v].i2, tbl[v].exp_n, tbl[v].exp_off);
    end

    // reset in mid-pass, checked asynchronously, then a clean pass
    fill(0);
    done_q.delete();
    @(negedge clk);
    start_cal = 1'b1;
    ts = cyc;
    @(negedge clk);
    start_cal = 1'b0;
    while (cyc < ts + 30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid", BW'(a_valid), BW'(0));
    chk("mr_ains", BW'(a_ins), BW'(0));
    chk("mr_busy", BW'(busy), BW'(0));
    chk("mr_en", BW'(bram_en_a), BW'(0));
    chk("mr_addr", BW'(bram_addr_a), BW'(BASE));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (90) @(negedge clk);
    chk("mr_nodone", BW'(done_q.size()), BW'(0));
    run_pass(0, -1, -1, 1, DONE_OFF);

    // back-to-back: start held high for 16 passes
    fill(0);
    done_q.delete();
    @(negedge clk);
    start_cal = 1'b1;
    ts = cyc;
    repeat (16*PASS_LEN - 1) @(negedge clk);
    start_cal = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b_n", BW'(done_q.size()), BW'(16));
    for (int j = 0; j < done_q.size() && j < 16; j++) begin
      if (j == 0) chk("b2b_first", BW'(done_q[0] - ts), BW'(DONE_OFF));
      else        chk("b2b_gap", BW'(done_q[j] - done_q[j-1]), BW'(PASS_LEN));
    end

    // randomized data, idle gaps and ignored start pulses
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_pass(1, $urandom_range(1, 82), $urandom_range(1, 82), 1, DONE_OFF);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scatter_a.md
Name: scatter_a

Overview:
- Feed side of the systolic array; sits opposite the C-result gather block.
- On start, streams DATA_A_SIZE_Y row-words of operand A out of the A-side BRAM, one per cycle.
- Applies a diagonal skew so that lane i lags lane 0 by i cycles, then drives a_ins into the array's west edge.
- Pulses scatter_done once the last skewed element has been presented.

Parameters:
- W, 8, element width in bits
- N, 16, array lanes (elements per row-word)
- BRAM_W, 256, BRAM data width; elements occupy bits [N*W-1:0], upper bits ignored
- BRAM_AW, 10, BRAM address width
- DATA_A_SIZE_Y, 64, rows streamed per pass (R)
- BASE_ADDR, 0, first BRAM word address; BASE_ADDR+R-1 must be < 2^BRAM_AW

Ports:
- clk  in  1  system clock; also drives bram_clk_a
- rst  in  1  asynchronous, active-high reset
- start_cal  in  1  level; sampled only in IDLE
- scatter_done  out  1  one-cycle pulse at end of pass
- busy  out  1  high in every state other than IDLE
- bram_clk_a  out  1  equals clk
- bram_en_a  out  1  BRAM read enable
- bram_we_a  out  1  tied 0 (read-only port)
- bram_addr_a  out  BRAM_AW  read address
- bram_wrdata_a  out  BRAM_W  tied 0
- bram_rddata_a  in  BRAM_W  read data, 1-cycle latency after en/addr
- a_ins  out  [N-1:0][W-1:0]  skewed operand per lane
- a_valid  out  N  per-lane valid

Behaviour:
- Reset values, asynchronous: state=IDLE; scatter_done, busy, bram_en_a, a_valid = 0; bram_addr_a = BASE_ADDR; a_ins = 0; all skew registers = 0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE -> READ: on the first edge where start_cal=1; call that edge cycle T0. READ runs cycles T0+1 .. T0+R.
- READ, cycle T0+1+k for k=0..R-1:
  - bram_en_a=1, bram_addr_a=BASE_ADDR+k.
  - Address counter is BRAM_AW wide and wraps mod 2^BRAM_AW; valid configurations never reach the wrap.
  - After k=R-1, go to DRAIN.
- Skew pipeline:
  - Row k's data appears on bram_rddata_a in cycle T0+2+k and is registered into lane stage 0.
  - Lane i element = bram_rddata_a[i*W +: W] passed through i further register stages.
  - Result: a_ins[i] = A[k][i] and a_valid[i]=1 in cycle T0+3+k+i.
- Invalid lane/cycle: a_ins[i]=0 and a_valid[i]=0. Invalid lanes carry zero, never stale data.
- DRAIN:
  - bram_en_a=0.
  - Lasts until the last element (lane N-1, row R-1) has been presented in cycle T0+R+N+1.
- DONE:
  - Occupies cycle T0+R+N+2; scatter_done=1 for exactly that cycle.
  - Next state is IDLE.
- busy is high from T0+1 through the DONE cycle inclusive.
- start_cal in any state other than IDLE is ignored; no queuing.
- start_cal still high in the cycle after DONE starts a new pass (back-to-back is legal).
- Reset mid-pass:
  - Immediate return to IDLE with all outputs at reset values.
  - Skew pipeline flushed; no partial scatter_done.
- bram_we_a=0 and bram_wrdata_a=0 at all times.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0, bram_addr_a=BASE_ADDR, busy=0, with no clock edge needed.
- Ramp pass, defaults: BRAM model returns byte value (row*16+lane)&0xFF in lane slot; start at T0 ->
  - a_ins[i]=(k*16+i)&0xFF exactly at T0+3+k+i;
  - a_valid[0] high for T0+3..T0+66;
  - a_valid[15] high for T0+18..T0+81;
  - scatter_done pulses once at T0+82.
- Address sequence: BASE_ADDR=100 -> bram_en_a high exactly 64 cycles with addresses 100..163 in order; bram_we_a never 1.
- Start while busy: pulse start_cal at T0+10 and T0+40 -> ignored; exactly one scatter_done, at T0+82.
- Back-to-back: hold start_cal high continuously ->
  - second pass READ begins at the cycle after DONE;
  - second pass's addresses restart at BASE_ADDR;
  - 16 consecutive passes yield 16 scatter_done pulses spaced 83 cycles apart.
- Reset mid-pass: assert rst at T0+30 for 2 cycles, then start again ->
  - no scatter_done from the aborted pass;
  - new pass output is identical to a clean pass;
  - no stale non-zero a_ins before the new pass's first valid cycle.
